// File: rtl/dead_time_gate_driver_if.sv
// Gate-driver request/command bundle: SPWM-side requests in, gate commands and status out.
interface dead_time_gate_driver_if #(
  parameter int unsigned DT_W = 8
);
  logic            en;
  logic            ph;
  logic            pl;
  logic [DT_W-1:0] dt;
  logic            fault_n;
  logic            clr;
  logic            gh;
  logic            gl;
  logic            flt;
  logic            ill;
  logic [1:0]      st;

  modport master (
    output en, ph, pl, dt, fault_n, clr,
    input  gh, gl, flt, ill, st
  );

  modport slave (
    input  en, ph, pl, dt, fault_n, clr,
    output gh, gl, flt, ill, st
  );
endinterface

// File: rtl/dead_time_gate_driver.sv
// Half-bridge gate driver: turns complementary PH/PL requests into GH/GL with programmable
// dead time before every turn-on, plus enable/fault kill and a latched fault flag.
module dead_time_gate_driver #(
  parameter int unsigned DT_W = 8
) (
  input logic                     clk,
  input logic                     rst,
  dead_time_gate_driver_if.slave  bus
);

  typedef enum logic [1:0] {
    StOff  = 2'd0,
    StDead = 2'd1,
    StOnH  = 2'd2,
    StOnL  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            tgt_h_q, tgt_h_d;
  logic            flt_q, flt_d;
  logic            ill_q;
  logic            gh_q;
  logic            gl_q;

  logic            req_hi;
  logic            req_lo;
  logic            req_none;
  logic            kill;
  logic [DT_W-1:0] dt_eff;

  always_comb begin
    req_hi   = bus.ph & ~bus.pl;
    req_lo   = bus.pl & ~bus.ph;
    req_none = ~(req_hi | req_lo);
    kill     = ~bus.en | ~bus.fault_n | flt_q;
    dt_eff   = (bus.dt == '0) ? DT_W'(1) : bus.dt;
  end

  // A sampled fault wins over a simultaneous clear.
  always_comb begin
    flt_d = flt_q;
    if (!bus.fault_n) begin
      flt_d = 1'b1;
    end else if (bus.clr) begin
      flt_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_h_d = tgt_h_q;
    if (kill) begin
      state_d = StOff;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StOff: begin
          if (!req_none) begin
            state_d = StDead;
            tgt_h_d = req_hi;
            cnt_d   = dt_eff;
          end
        end
        StDead: begin
          if (req_none) begin
            state_d = StOff;
            cnt_d   = '0;
          end else if (req_hi != tgt_h_q) begin
            // Request swapped sides mid-dead-time: restart the full gap.
            tgt_h_d = req_hi;
            cnt_d   = dt_eff;
          end else if (cnt_q == DT_W'(1)) begin
            state_d = tgt_h_q ? StOnH : StOnL;
            cnt_d   = '0;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DT_W'(1);
          end
        end
        StOnH: begin
          if (req_lo) begin
            state_d = StDead;
            tgt_h_d = 1'b0;
            cnt_d   = dt_eff;
          end else if (req_none) begin
            state_d = StOff;
          end
        end
        StOnL: begin
          if (req_hi) begin
            state_d = StDead;
            tgt_h_d = 1'b1;
            cnt_d   = dt_eff;
          end else if (req_none) begin
            state_d = StOff;
          end
        end
        default: state_d = StOff;
      endcase
    end
  end

  // Gate commands are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StOff;
      cnt_q   <= '0;
      tgt_h_q <= 1'b1;
      flt_q   <= 1'b0;
      ill_q   <= 1'b0;
      gh_q    <= 1'b0;
      gl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_h_q <= tgt_h_d;
      flt_q   <= flt_d;
      ill_q   <= bus.ph & bus.pl;
      gh_q    <= (state_d == StOnH);
      gl_q    <= (state_d == StOnL);
    end
  end

  assign bus.gh  = gh_q;
  assign bus.gl  = gl_q;
  assign bus.flt = flt_q;
  assign bus.ill = ill_q;
  assign bus.st  = state_q;

endmodule

// File: tb/tb_dead_time_gate_driver.sv
// Directed bench for dead_time_gate_driver: dead time, filtering, retarget, fault, ILL, enable.
module tb_dead_time_gate_driver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_bad = 0;

  dead_time_gate_driver_if #(.DT_W(8)) bus ();

  dead_time_gate_driver #(.DT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) check("excl", {31'b0, bus.gh & bus.gl}, 32'd0);
  end

  initial begin
    bus.en = 1'b0; bus.ph = 1'b0; bus.pl = 1'b0; bus.dt = 8'd20;
    bus.fault_n = 1'b1; bus.clr = 1'b0;

    // Reset / idle
    #2 rst = 1'b1;
    #1;
    check("rst_st", bus.st, 0);
    check("rst_gh", bus.gh, 0);
    check("rst_gl", bus.gl, 0);
    check("rst_flt", bus.flt, 0);
    check("rst_ill", bus.ill, 0);
    step(2);
    rst = 1'b0; bus.en = 1'b1;
    step(5);
    check("idle_st", bus.st, 0);
    check("idle_gh", bus.gh, 0);
    check("idle_flt", bus.flt, 0);

    // Basic dead time, DT=20
    bus.ph = 1'b1;
    step(1);  check("b_dead", bus.st, 1);
    step(19); check("b_gh_k19", bus.gh, 0); check("b_st_k19", bus.st, 1);
    step(1);  check("b_gh_k20", bus.gh, 1); check("b_onh", bus.st, 2);
    step(10); check("b_gh_hold", bus.gh, 1);
    bus.ph = 1'b0; bus.pl = 1'b1;
    step(1);  check("b_gh_off", bus.gh, 0); check("b_gl_k0", bus.gl, 0); check("b_st_d", bus.st, 1);
    step(19); check("b_gl_k19", bus.gl, 0);
    step(1);  check("b_gl_k20", bus.gl, 1); check("b_onl", bus.st, 3);
    bus.pl = 1'b0;
    step(1);  check("b_gl_off", bus.gl, 0); check("b_off", bus.st, 0);

    // Short pulse filtering: 10, 20 and 25 cycle requests
    bus.ph = 1'b1;
    step(10); check("s10_st", bus.st, 1); check("s10_gh", bus.gh, 0);
    bus.ph = 1'b0;
    step(1);  check("s10_off", bus.st, 0); check("s10_gh2", bus.gh, 0);
    bus.ph = 1'b1;
    step(20); check("s20_gh", bus.gh, 0);
    bus.ph = 1'b0;
    step(1);  check("s20_gh2", bus.gh, 0); check("s20_off", bus.st, 0);
    bus.ph = 1'b1;
    step(20); check("s25_gh_k19", bus.gh, 0);
    step(1);  check("s25_gh_k20", bus.gh, 1);
    step(4);  check("s25_gh_k24", bus.gh, 1);
    bus.ph = 1'b0;
    step(1);  check("s25_gh_off", bus.gh, 0); check("s25_off", bus.st, 0);

    // DT=0 behaves as a 1-cycle gap
    bus.dt = 8'd0; bus.ph = 1'b1;
    step(1); check("z_dead", bus.st, 1); check("z_gh0", bus.gh, 0);
    step(1); check("z_gh1", bus.gh, 1); check("z_onh", bus.st, 2);
    bus.ph = 1'b0; bus.pl = 1'b1;
    step(1); check("z_gap_st", bus.st, 1); check("z_gap_gh", bus.gh, 0); check("z_gap_gl", bus.gl, 0);
    step(1); check("z_gl1", bus.gl, 1); check("z_onl", bus.st, 3);
    bus.pl = 1'b0;
    step(1); check("z_off", bus.st, 0);

    // Retarget mid-dead-time reloads the counter; DT change mid-count ignored
    bus.dt = 8'd20; bus.ph = 1'b1;
    step(1);  check("r_dead", bus.st, 1);
    step(9);  check("r_dead9", bus.st, 1);
    bus.ph = 1'b0; bus.pl = 1'b1;
    step(1);  check("r_flip", bus.st, 1);
    bus.dt = 8'd5;
    step(19); check("r_gl_f19", bus.gl, 0); check("r_st_f19", bus.st, 1);
    step(1);  check("r_gl_f20", bus.gl, 1); check("r_onl", bus.st, 3);
    bus.dt = 8'd20; bus.pl = 1'b0;
    step(1);  check("r_off", bus.st, 0);

    // Fault latch and clear
    bus.ph = 1'b1;
    step(20); check("f_gh_pre", bus.gh, 0);
    step(1);  check("f_gh_on", bus.gh, 1);
    bus.fault_n = 1'b0;
    step(1);  check("f_gh_kill", bus.gh, 0); check("f_flt", bus.flt, 1); check("f_off", bus.st, 0);
    bus.fault_n = 1'b1;
    step(3);  check("f_gh_held", bus.gh, 0); check("f_flt_held", bus.flt, 1);
    check("f_st_held", bus.st, 0);
    bus.clr = 1'b1; bus.fault_n = 1'b0;
    step(1);  check("f_clr_vs_fault", bus.flt, 1);
    bus.fault_n = 1'b1;
    step(1);  check("f_clr", bus.flt, 0); check("f_clr_st", bus.st, 0);
    check("f_clr_gh", bus.gh, 0);
    bus.clr = 1'b0;
    step(1);  check("f_resume", bus.st, 1);
    step(19); check("f_gh_c20", bus.gh, 0);
    step(1);  check("f_gh_c21", bus.gh, 1);

    // Illegal request in ON_L
    bus.ph = 1'b0; bus.pl = 1'b1;
    step(20); check("i_gl_pre", bus.gl, 0);
    step(1);  check("i_gl_on", bus.gl, 1); check("i_onl", bus.st, 3); check("i_ill0", bus.ill, 0);
    bus.ph = 1'b1;
    step(1);  check("i_gl_off", bus.gl, 0); check("i_off", bus.st, 0); check("i_ill1", bus.ill, 1);
    step(1);  check("i_ill2", bus.ill, 1);
    step(1);  check("i_ill3", bus.ill, 1);
    bus.ph = 1'b0; bus.pl = 1'b0;
    step(1);  check("i_ill_end", bus.ill, 0); check("i_st", bus.st, 0);

    // Enable removal in DEAD, no fault latched
    bus.ph = 1'b1;
    step(1);  check("e_dead", bus.st, 1);
    bus.en = 1'b0;
    step(1);  check("e_off", bus.st, 0); check("e_flt", bus.flt, 0);
    bus.en = 1'b1;
    step(1);  check("e_reentry", bus.st, 1);
    step(20); check("e_gh", bus.gh, 1); check("e_onh", bus.st, 2);

    // Asynchronous reset mid-ON drops the gate without a clock edge
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("a_gh", bus.gh, 0);
    check("a_st", bus.st, 0);
    step(1);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/dead_time_gate_driver.md
Name: dead_time_gate_driver

Overview:
- Consumes the PH/PL complementary switching requests from the SPWM generator and produces the power-stage gate commands GH/GL.
- Guarantees GH and GL are never both high and inserts a programmable dead time before any gate turns on.
- Forces both gates off on enable removal or an external fault; the fault is latched until cleared.
- Sits directly downstream of the SPWM generator and immediately ahead of the half-bridge driver pins.

Parameters:
- DT_W, 8: width of the dead-time count input DT.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- EN  in  1  bridge enable; low forces both gates off without latching.
- PH  in  1  high-side on request from the SPWM generator (same clock domain, no synchroniser).
- PL  in  1  low-side on request from the SPWM generator.
- DT  in  DT_W  dead time in CLK cycles; sampled on each entry to DEAD; value 0 is treated as 1.
- FAULT_N  in  1  external fault, active-low, synchronous to CLK.
- CLR  in  1  clears the latched fault.
- GH  out  1  high-side gate command.
- GL  out  1  low-side gate command.
- FLT  out  1  latched fault flag.
- ILL  out  1  one-cycle pulse for each cycle in which PH=PL=1 is sampled.
- ST  out  2  state code: OFF=0, DEAD=1, ON_H=2, ON_L=3.

Behaviour:
- Reset (RST high, asynchronous): state OFF, GH=0, GL=0, FLT=0, ILL=0, counter=0, target=H.
- Request decode, evaluated each edge:
  - HI when PH & !PL.
  - LO when PL & !PH.
  - NONE when PH and PL are equal (both 0 or both 1).
  - PH=PL=1 also sets ILL=1 on the next edge, for one cycle per sampled cycle.
- Outputs are Moore-decoded from the state register: GH=1 only in ON_H, GL=1 only in ON_L. GH&GL=1 is unreachable.
- Let D = max(DT,1), sampled when DEAD is entered or re-entered.
- Kill condition, highest priority: EN=0, or FAULT_N=0, or FLT=1. On kill the next state is OFF from any state.
- FAULT_N=0 sampled sets FLT=1. FLT clears only on an edge with CLR=1 and FAULT_N=1. On the clear edge the state remains OFF; normal operation resumes on the following edge.
- OFF:
  - HI → DEAD with target H, counter=D.
  - LO → DEAD with target L, counter=D.
  - NONE → stay in OFF.
- DEAD:
  - Counter decrements by 1 per edge.
  - When counter==1 and the request still equals the target, next state is ON_target.
  - Request becomes NONE → OFF.
  - Request flips to the opposite side → retarget, counter reloads with the current D (dead time restarts).
  - Counter never underflows.
- ON_H:
  - HI → stay.
  - NONE → OFF next edge (turn-off is immediate).
  - LO → DEAD with target L, counter=D.
- ON_L: mirror of ON_H.
- Latency:
  - A request first sampled at edge k while in OFF or ON_opposite gives gate-on at edge k+D.
  - Gate-off always takes 1 edge after the request is sampled.
- Simultaneous kill and request: kill wins.
- Simultaneous CLR and FAULT_N=0: FLT stays 1.
- DT changing while counting has no effect until the next DEAD entry or reload.
- RST mid-DEAD or mid-ON: both gates drop immediately (asynchronously).

Test Plan:
1. Reset/idle: RST pulse, EN=1, PH=PL=0 → GH=GL=0, ST=0, FLT=0 indefinitely.
2. Basic dead time: DT=20, EN=1, PH toggles every 200 cycles (PL=!PH) → each GH and GL rising edge lags its request by exactly 20 cycles; each falling edge lags by 1 cycle; GH&GL never 1 (bench assertion every cycle).
3. Short pulse filtering: DT=20, PH high for 10 cycles from OFF → GH stays 0, ST goes 1→0. Then PH high for 20 cycles → GH high exactly 1 cycle… no, 0 cycles: GH rises at k+20 when PH has dropped, so GH stays 0. Then 25 cycles → GH high for 5 cycles.
4. DT=0 and retarget: DT=0 gives a 1-cycle gap on each transition. With DT=20, PH→PL flip at cycle 10 of DEAD → counter reloads, GL rises 20 cycles after the flip.
5. Fault: in ON_H, FAULT_N=0 for 1 cycle → GH=0 next edge, FLT=1. PH stays high and GH stays 0. CLR=1 with FAULT_N=1 → FLT=0, GH rises 20 cycles after the first post-clear request edge.
6. Illegal request and enable: PH=PL=1 for 3 cycles in ON_L → GL off next edge, ILL high for 3 cycles. EN=0 in DEAD → OFF, FLT remains 0.
